switch_sequence_controller: RTL and testbench

//  Plays a programmed sequence of photonic-switch patterns, each held for a programmable dwell time.

---
 rtl/switch_sequence_controller.sv | 130 +++++++++++++
 tb/tb_switch_sequence_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_sequence_controller.sv
// Plays a table of {pattern, dwell} steps onto the switch driver, timing each step with an external down-counter.
// Optional build macro SEQ_LOOP_EN: replay the sequence continuously until abort instead of ending in DONE.
module switch_sequence_controller #(
  parameter int unsigned STEPS        = 8,
  parameter int unsigned SW_WIDTH     = 4,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned SAFE_PATTERN = 0,
  localparam int unsigned AW          = $clog2(STEPS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [SW_WIDTH+CNT_WIDTH-1:0] wr_data,
  input  logic [AW:0]                   num_steps,
  input  logic                          start,
  input  logic                          abort,
  input  logic [CNT_WIDTH-1:0]          cnt_q,
  output logic                          cnt_load,
  output logic                          cnt_en,
  output logic [CNT_WIDTH-1:0]          cnt_limit,
  output logic [SW_WIDTH-1:0]           switch_out,
  output logic [AW-1:0]                 step_idx,
  output logic                          busy,
  output logic                          done
);

  localparam logic [SW_WIDTH-1:0] SAFE    = SAFE_PATTERN[SW_WIDTH-1:0];
  localparam logic [AW:0]         STEPS_W = STEPS[AW:0];
  localparam logic [AW:0]         ONE_W   = 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [SW_WIDTH-1:0]   pat_tab   [STEPS];
  logic [CNT_WIDTH-1:0]  dwell_tab [STEPS];
  logic [AW:0]           n_latched, n_nxt;
  logic [AW-1:0]         idx_nxt;
  logic [AW:0]           idx_plus1;
  logic                  done_nxt;
  logic [SW_WIDTH-1:0]   sw_nxt;

  // Table has no reset; contents survive reset and abort.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && ({1'b0, wr_addr} < STEPS_W)) begin
      pat_tab[wr_addr]   <= wr_data[SW_WIDTH+CNT_WIDTH-1:CNT_WIDTH];
      dwell_tab[wr_addr] <= wr_data[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      n_latched  <= '0;
      step_idx   <= '0;
      switch_out <= SAFE;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      n_latched  <= n_nxt;
      step_idx   <= idx_nxt;
      switch_out <= sw_nxt;
      done       <= done_nxt;
    end
  end

  assign idx_plus1 = {1'b0, step_idx} + ONE_W;

  always_comb begin
    state_nxt = state;
    n_nxt     = n_latched;
    idx_nxt   = step_idx;
    done_nxt  = 1'b0;
    sw_nxt    = switch_out;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          idx_nxt = '0;
          if (num_steps != '0) begin
            state_nxt = S_LOAD;
            n_nxt     = (num_steps > STEPS_W) ? STEPS_W : num_steps;
          end else begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        sw_nxt    = pat_tab[step_idx];
        state_nxt = S_COUNT;
      end
      S_COUNT: begin
        if (cnt_q == '0) begin
          if (idx_plus1 < n_latched) begin
            state_nxt = S_LOAD;
            idx_nxt   = idx_plus1[AW-1:0];
          end else begin
`ifdef SEQ_LOOP_EN
            // Wrap-around LOAD carries the per-pass done pulse.
            state_nxt = S_LOAD;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
`else
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
`endif
          end
        end
      end
      S_DONE: begin
        sw_nxt    = SAFE;
        idx_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      done_nxt  = 1'b0;
      sw_nxt    = SAFE;
    end
  end

  assign busy      = (state == S_LOAD) || (state == S_COUNT);
  assign cnt_load  = (state == S_LOAD);
  assign cnt_en    = (state == S_COUNT);
  assign cnt_limit = busy ? dwell_tab[step_idx] : '0;

endmodule

// File: tb/tb_switch_sequence_controller.sv
// Self-checking bench for switch_sequence_controller with an environment dwell counter and a trace-level reference model.
module tb_switch_sequence_controller;

  localparam int unsigned STEPS = 8;
  localparam int unsigned SW    = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned AW    = 3;
  localparam logic [SW-1:0] SAFE = 4'h6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, wr_en, start, abort;
  logic [AW-1:0]  wr_addr;
  logic [SW+CW-1:0] wr_data;
  logic [AW:0]    num_steps;
  logic [CW-1:0]  cnt_q;
  logic           cnt_load, cnt_en, busy, done;
  logic [CW-1:0]  cnt_limit;
  logic [SW-1:0]  switch_out;
  logic [AW-1:0]  step_idx;

  switch_sequence_controller #(
    .STEPS(STEPS), .SW_WIDTH(SW), .CNT_WIDTH(CW), .SAFE_PATTERN(6)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_steps(num_steps), .start(start), .abort(abort), .cnt_q(cnt_q),
    .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_limit(cnt_limit),
    .switch_out(switch_out), .step_idx(step_idx), .busy(busy), .done(done)
  );

  // Environment: the downward dwell counter the controller drives.
  always_ff @(posedge clk) begin
    if (reset)                    cnt_q <= '0;
    else if (cnt_load)            cnt_q <= cnt_limit;
    else if (cnt_en && cnt_q != 0) cnt_q <= cnt_q - 1'b1;
  end

  typedef struct {
    logic [SW-1:0] sw;
    logic          bsy, dn, ld, en;
    logic [CW-1:0] lim;
    logic [AW-1:0] idx;
    logic          chk_idx;
    int            act;   // 0 none, 1 abort, 2 reset driven during this cycle
  } ent_t;

  ent_t          exp_q[$];
  logic [SW-1:0] sh_pat [STEPS];
  logic [CW-1:0] sh_dw  [STEPS];
  int n_cmp = 0;
  int n_err = 0;

  function automatic ent_t mk(logic [SW-1:0] sw, logic bsy, logic dn, logic ld, logic en,
                              logic [CW-1:0] lim, logic [AW-1:0] idx, logic ci);
    ent_t e;
    e.sw = sw; e.bsy = bsy; e.dn = dn; e.ld = ld; e.en = en;
    e.lim = lim; e.idx = idx; e.chk_idx = ci; e.act = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_ent(input ent_t e);
    chk("switch_out", 32'(switch_out), 32'(e.sw));
    chk("busy",       32'(busy),       32'(e.bsy));
    chk("done",       32'(done),       32'(e.dn));
    chk("cnt_load",   32'(cnt_load),   32'(e.ld));
    chk("cnt_en",     32'(cnt_en),     32'(e.en));
    chk("cnt_limit",  32'(cnt_limit),  32'(e.lim));
    if (e.chk_idx) chk("step_idx", 32'(step_idx), 32'(e.idx));
  endtask

  // Expected per-cycle trace, starting with the cycle after the start edge.
  task automatic build(input int n_req, input int act_in, input int at_in);
    int n, act, at;
    logic [SW-1:0] prev;
    ent_t e;
    act = act_in; at = at_in;
    n = (n_req > STEPS) ? STEPS : n_req;
    exp_q.delete();
    if (n == 0) begin
      exp_q.push_back(mk(SAFE, 0, 1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(SAFE, 0, 0, 0, 0, 0, 0, 0));
      return;
    end
    prev = SAFE;
`ifdef SEQ_LOOP_EN
    for (int p = 0; p < 2; p++) begin
`else
    for (int p = 0; p < 1; p++) begin
`endif
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(mk(prev, 1, (p > 0 && i == 0), 1, 0, sh_dw[i], AW'(i), 1));
        for (int c = 0; c <= int'(sh_dw[i]); c++)
          exp_q.push_back(mk(sh_pat[i], 1, 0, 0, 1, sh_dw[i], AW'(i), 1));
        prev = sh_pat[i];
      end
    end
`ifdef SEQ_LOOP_EN
    exp_q.push_back(mk(prev, 1, 1, 1, 0, sh_dw[0], 0, 1));
    if (act == 0) begin act = 1; at = exp_q.size() - 1; end
`else
    exp_q.push_back(mk(prev, 0, 1, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(SAFE, 0, 0, 0, 0, 0, 0, 0));
`endif
    if (act != 0 && at < exp_q.size()) begin
      exp_q = exp_q[0:at];
      e = exp_q[at]; e.act = act; exp_q[at] = e;
      exp_q.push_back(mk(SAFE, 0, 0, 0, 0, 0, 0, 1));
    end
  endtask

  task automatic run(input int n, input int act, input int at);
    build(n, act, at);
    @(negedge clk);
    num_steps = (AW+1)'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (exp_q[k]) begin
      check_ent(exp_q[k]);
      // Writes and starts while busy must be ignored.
      if (exp_q[k].bsy && exp_q[k].act == 0) begin
        wr_en     = 1'($urandom_range(0, 1));
        wr_addr   = AW'($urandom);
        wr_data   = (SW+CW)'($urandom);
        start     = 1'($urandom_range(0, 1));
        num_steps = (AW+1)'($urandom);
      end
      if (exp_q[k].act == 1) abort = 1'b1;
      if (exp_q[k].act == 2) reset = 1'b1;
      @(negedge clk);
      abort = 1'b0; reset = 1'b0; wr_en = 1'b0; start = 1'b0;
    end
  endtask

  task automatic write_tab(input int a, input logic [SW-1:0] p, input logic [CW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = {p, d};
    @(negedge clk);
    wr_en = 1'b0;
    sh_pat[a] = p; sh_dw[a] = d;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    wr_addr = '0; wr_data = '0; num_steps = '0;
    repeat (2) @(negedge clk);
    check_ent(mk(SAFE, 0, 0, 0, 0, 0, 0, 1));
    reset = 1'b0;

    // Two-step sequence with dwells 3 and 0.
    write_tab(0, 4'hA, 16'd3);
    write_tab(1, 4'h5, 16'd0);
    run(2, 0, 0);

    // Empty sequence: immediate done, no busy.
    run(0, 0, 0);

    for (int i = 0; i < STEPS; i++)
      write_tab(i, SW'($urandom), CW'($urandom_range(0, 6)));

    repeat (15) begin
      if ($urandom_range(0, 1) == 1)
        write_tab($urandom_range(0, STEPS - 1), SW'($urandom), CW'($urandom_range(0, 6)));
      run($urandom_range(0, 10), 0, 0);
    end

    // Abort in the 10th COUNT cycle of a long step.
    write_tab(0, 4'hC, 16'd100);
    run(1, 1, 10);

    // Reset mid-COUNT, then replay from step 0 with the table intact.
    run(3, 2, 5);
    run(3, 0, 0);

    // abort beats start in IDLE.
    @(negedge clk);
    num_steps = '0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    chk("abort_start_done", 32'(done), 32'd0);
    num_steps = 4'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start2_busy", 32'(busy), 32'd0);
    chk("abort_start2_sw",   32'(switch_out), 32'(SAFE));

`ifdef SEQ_LOOP_EN
    write_tab(0, 4'h1, 16'd1);
    write_tab(1, 4'h2, 16'd2);
    run(2, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
